// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains a FIFO one word at a time and sends each word as a
// UART-style frame on a single wire. The frame is a start bit (0), then
// Word_Length data bits LSB first, then a stop bit (1). Every output is
// registered and is computed from the next-state values.
module fifo_serial_tx #(
  parameter int Word_Length      = 16,
  parameter int Bit_Period       = 4,
  parameter int NBITS_FOR_BITCNT = $clog2(Word_Length),
  parameter int NBITS_FOR_PERIOD = $clog2(Bit_Period)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [Word_Length-1:0] fifo_data,
  output logic                   fifo_pop,
  output logic                   serial_out,
  output logic                   busy,
  output logic                   word_done
);

  // Widths of at least one bit, so Word_Length=1 or Bit_Period=1 still elaborate.
  localparam int BW = (NBITS_FOR_BITCNT < 1) ? 1 : NBITS_FOR_BITCNT;
  localparam int PW = (NBITS_FOR_PERIOD < 1) ? 1 : NBITS_FOR_PERIOD;
  localparam logic [BW-1:0] BIT_LAST = BW'(Word_Length - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(Bit_Period - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t                 state, state_nxt;
  logic [PW-1:0]          period_cnt, period_cnt_nxt;
  logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
  logic [Word_Length-1:0] shift, shift_nxt;
  logic                   serial_nxt, pop_nxt, busy_nxt, done_nxt;
  logic                   period_last;
  logic                   can_start;

  assign period_last = (period_cnt == PER_LAST);
  assign can_start   = enable && !fifo_empty;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      period_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
      fifo_pop   <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      period_cnt <= period_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      serial_out <= serial_nxt;
      fifo_pop   <= pop_nxt;
      busy       <= busy_nxt;
      word_done  <= done_nxt;
    end
  end

  // Next-state, counter and shift-register logic; counters wrap at every bit boundary.
  always_comb begin
    state_nxt      = state;
    period_cnt_nxt = '0;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    case (state)
      IDLE: begin
        if (can_start) state_nxt = POP;
      end
      POP: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        // DataOutput is valid the cycle after the pop request.
        shift_nxt   = fifo_data;
        bit_cnt_nxt = '0;
        state_nxt   = START;
      end
      START: begin
        if (period_last) state_nxt = DATA;
        else period_cnt_nxt = period_cnt + PW'(1);
      end
      DATA: begin
        if (period_last) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end else begin
          period_cnt_nxt = period_cnt + PW'(1);
        end
      end
      STOP: begin
        // Chain straight into the next pop so back-to-back frames have no idle gap.
        if (period_last) state_nxt = can_start ? POP : IDLE;
        else period_cnt_nxt = period_cnt + PW'(1);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    serial_nxt = 1'b1;
    pop_nxt    = (state_nxt == POP);
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = (state_nxt == STOP) && (period_cnt_nxt == PER_LAST);
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
      default: serial_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-backed FIFO model feeds the DUT, words are
// expected in push order, and a line monitor rebuilds every frame from the
// frame rules and compares it with the scoreboard.
`timescale 1ns/1ps
module tb_fifo_serial_tx;
  localparam int WL     = 16;
  localparam int BP     = 4;
  localparam int FRAME  = (WL + 2) * BP;
  localparam int PERIOD = FRAME + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [WL-1:0] fifo_data = '0;
  logic          fifo_pop;
  logic          serial_out;
  logic          busy;
  logic          word_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  fifo_serial_tx #(.Word_Length(WL), .Bit_Period(BP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .serial_out(serial_out),
    .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read data, one word per pop.
  logic [WL-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_pop && rd_ptr != wr_ptr) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [WL-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [WL-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // Line monitor state.
  bit            in_frame = 0;
  int            pos = 0;
  int            frames_done = 0;
  int            pop_count = 0;
  int            start_q [$];
  int            popc_q [$];
  logic [WL-1:0] exp_w = '0;
  logic [WL-1:0] rx = '0;
  int            bad_bits = 0, done_cnt = 0, done_pos = -1, busy_bad = 0;
  logic          prev_pop = 1'b0, prev_empty = 1'b1, prev_enable = 1'b0;

  function automatic int pop_at(input int i);
    return (i < popc_q.size()) ? popc_q[i] : -1;
  endfunction

  function automatic int start_at(input int i);
    return (i < start_q.size()) ? start_q[i] : -1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 0;
      end else begin
        if (fifo_pop) begin
          chk("pop_legal", {29'd0, prev_pop, prev_empty, !prev_enable}, 32'd0);
          popc_q.push_back(cyc);
          pop_count++;
        end
        if (!in_frame && serial_out == 1'b0) begin
          in_frame = 1;
          pos = 0;
          bad_bits = 0; done_cnt = 0; done_pos = -1; busy_bad = 0; rx = '0;
          start_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: start bit at cycle %0d with no word expected", cyc);
            exp_w = '0;
          end else begin
            exp_w = exp_q.pop_front();
          end
        end else if (!in_frame && word_done) begin
          chk("done_outside_frame", word_done, 1'b0);
        end
        if (in_frame) begin
          int  bi;
          logic eb;
          bi = pos / BP;
          if (bi == 0) eb = 1'b0;
          else if (bi <= WL) eb = exp_w[bi-1];
          else eb = 1'b1;
          if (serial_out !== eb) bad_bits++;
          if (bi >= 1 && bi <= WL && (pos % BP) == BP / 2) rx[bi-1] = serial_out;
          if (word_done) begin done_cnt++; done_pos = pos; end
          if (!busy) busy_bad++;
          if (pos == FRAME - 1) begin
            chk("rx_word", rx, exp_w);
            chk("frame_bad_cycles", bad_bits, 0);
            chk("done_count", done_cnt, 1);
            chk("done_position", done_pos, FRAME - 1);
            chk("busy_in_frame", busy_bad, 0);
            frames_done++;
            in_frame = 0;
          end else begin
            pos++;
          end
        end
      end
      prev_pop    = fifo_pop;
      prev_empty  = fifo_empty;
      prev_enable = enable;
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin @(posedge clk); k++; end
    chk("frames_reached", frames_done >= target, 1);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k = 0;
    while (pop_count < target && k < budget) begin @(posedge clk); k++; end
    chk("pops_reached", pop_count >= target, 1);
  endtask

  task automatic wait_pos(input int p, input int budget);
    int k = 0;
    while (!(in_frame && pos == p) && k < budget) begin @(posedge clk); k++; end
    chk("frame_pos_reached", in_frame && pos == p, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int target;
    int k;

    // Reset hold with a non-empty FIFO and enable high.
    reset  = 1'b1;
    enable = 1'b1;
    push_word(16'h00A5);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_serial", serial_out, 1'b1);
      chk("rst_pop", fifo_pop, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", word_done, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rel_cyc = cyc;
    wait_pops(1, 20);
    chk("pop_after_reset", pop_at(0), rel_cyc + 1);

    // Single word 16'h00A5.
    wait_frames(1, 200);
    chk("start_latency_0", start_at(0), pop_at(0) + 2);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_serial", serial_out, 1'b1);

    // Back-to-back frames.
    @(posedge clk); #1;
    push_word(16'd8);
    push_word(16'd7);
    push_word(16'd6);
    wait_frames(4, 4 * PERIOD + 50);
    for (int i = 1; i < 4; i++) chk("b2b_start_latency", start_at(i), pop_at(i) + 2);
    for (int i = 2; i < 4; i++) begin
      chk("b2b_pop_spacing", pop_at(i) - pop_at(i-1), PERIOD);
      chk("b2b_start_spacing", start_at(i) - start_at(i-1), PERIOD);
    end
    repeat (10) @(posedge clk);
    chk("b2b_pop_count", pop_count, 4);

    // Empty FIFO with enable high.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("empty_pop", fifo_pop, 1'b0);
      chk("empty_serial", serial_out, 1'b1);
    end

    // Enable dropped during data bit 5 of 16'h1234, FIFO still holding a word.
    @(posedge clk); #1;
    push_word(16'h1234);
    push_word(16'h5A5A);
    wait_pos(26, 100);
    #1;
    enable = 1'b0;
    wait_frames(5, FRAME + 10);
    repeat (100) @(posedge clk);
    chk("drop_pop_count", pop_count, 5);
    @(negedge clk);
    chk("drop_busy", busy, 1'b0);
    chk("drop_serial", serial_out, 1'b1);

    // Reset pulse during data bit 3; the in-flight 16'h5A5A is discarded.
    @(posedge clk); #1;
    enable = 1'b1;
    push_word(16'hC3C3);
    wait_pos(18, 100);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rel_cyc = cyc;
    @(negedge clk);
    chk("midrst_serial", serial_out, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_pop", fifo_pop, 1'b0);
    wait_pops(7, 20);
    chk("pop_after_midreset", pop_at(6), rel_cyc + 1);
    wait_frames(6, FRAME + 20);
    chk("fresh_start_latency", start_at(6), pop_at(6) + 2);

    // Random words with enable toggling randomly.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push_word(WL'($urandom));
    target = frames_done + 5;
    k = 0;
    while (frames_done < target && k < 3000) begin
      @(posedge clk); #1;
      enable = ($urandom_range(0, 3) != 0);
      k++;
    end
    enable = 1'b1;
    chk("random_frames_reached", frames_done >= target, 1);
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("fifo_drained", fifo_empty, 1'b1);
    @(negedge clk);
    chk("final_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
